// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: word-aligned memory transactions with byte strobes, load lane extraction and extension.
// Optional macro TINY5_LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into error responses.
module load_store_unit (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_store_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_error_o,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_REQ        = 2'd1;
  localparam logic [1:0] S_WAIT_RDATA = 2'd2;
  localparam logic [1:0] S_RESP       = 2'd3;

  logic [1:0]  state;
  logic [2:0]  funct3_p1;
  logic [1:0]  off_p1;
  logic        write_p1;
  logic [31:0] addr_p1;
  logic [3:0]  wstrb_p1;
  logic [31:0] wdata_p1;
  logic [31:0] rdata_p2;
  logic        error_p2;
  logic        accept;
  logic        misaligned;
  logic        illegal;

  function automatic logic funct3_illegal(input logic store, input logic [2:0] f3);
    if (store)
      return f3[2] || (f3[1:0] == 2'b11);
    else
      return (f3[1:0] == 2'b11) || (f3[2] && f3[1]);
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3[1:0])
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [3:0] store_strobes(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Halfwords select on addr[1] only, so a stray addr[0] never shifts the lane.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] ext;
    byte_s = 8'(word >> {off, 3'b000});
    half_s = 16'(word >> {off[1], 4'b0000});
    case (f3)
      3'b000:  ext = 32'(byte_s);
      3'b001:  ext = 32'(half_s);
      3'b100:  ext = {24'd0, byte_s};
      3'b101:  ext = {16'd0, half_s};
      default: ext = word;
    endcase
    return ext;
  endfunction

`ifdef TINY5_LSU_MISALIGN_TRAP_EN
  assign misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                      ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign accept  = req_valid_i && (state == S_IDLE);
  assign illegal = funct3_illegal(req_store_i, req_funct3_i) || misaligned;

  assign req_ready_o  = (state == S_IDLE);
  assign mem_valid_o  = (state == S_REQ);
  assign resp_valid_o = (state == S_RESP);
  assign mem_write_o  = write_p1;
  assign mem_addr_o   = addr_p1;
  assign mem_wstrb_o  = wstrb_p1;
  assign mem_wdata_o  = wdata_p1;
  assign resp_rdata_o = rdata_p2;
  assign resp_error_o = error_p2;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= S_IDLE;
      funct3_p1 <= 3'd0;
      off_p1    <= 2'd0;
      write_p1  <= 1'b0;
      addr_p1   <= 32'd0;
      wstrb_p1  <= 4'd0;
      wdata_p1  <= 32'd0;
      rdata_p2  <= 32'd0;
      error_p2  <= 1'b0;
    end else begin
      case (state)
        // p1: request captured, memory transaction prepared
        S_IDLE: begin
          if (accept) begin
            funct3_p1 <= req_funct3_i;
            off_p1    <= req_addr_i[1:0];
            rdata_p2  <= 32'd0;
            error_p2  <= illegal;
            if (illegal) begin
              state <= S_RESP;
            end else begin
              state    <= S_REQ;
              write_p1 <= req_store_i;
              addr_p1  <= {req_addr_i[31:2], 2'b00};
              wstrb_p1 <= req_store_i ? store_strobes(req_funct3_i, req_addr_i[1:0]) : 4'd0;
              wdata_p1 <= req_store_i ? store_lanes(req_funct3_i, req_wdata_i) : 32'd0;
            end
          end
        end
        S_REQ: begin
          if (mem_ready_i)
            state <= write_p1 ? S_RESP : S_WAIT_RDATA;
        end
        // p2: load data extended into the response register
        S_WAIT_RDATA: begin
          if (mem_rvalid_i) begin
            rdata_p2 <= load_extend(funct3_p1, off_p1, mem_rdata_i);
            state    <= S_RESP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit for the tiny5 core, sitting between the execute stage (which supplies the ALU-computed effective address, store data and funct3) and the data memory port. Converts LB/LH/LW/LBU/LHU and SB/SH/SW requests into word-aligned memory transactions with byte strobes. Performs lane extraction and sign/zero extension on load data, and returns one response pulse per accepted request.

## Interface
Parameters:
- None. Data and address widths are fixed at 32 bits.

Ports:
- clk_i  in  1  core clock.
- reset_i  in  1  reset; asynchronous, active-high.
- req_valid_i  in  1  execute stage presents a request.
- req_ready_o  out  1  unit can accept; high only in IDLE.
- req_store_i  in  1  1 = store (funct3_store_t), 0 = load (funct3_load_t).
- req_funct3_i  in  3  access size/sign.
- req_addr_i  in  32  effective byte address (ALU out).
- req_wdata_i  in  32  rs2 value for stores.
- resp_valid_o  out  1  one-cycle response pulse; no backpressure.
- resp_rdata_o  out  32  extended load data; 0 for stores and errors.
- resp_error_o  out  1  illegal funct3 (or misaligned, see Configuration).
- mem_valid_o  out  1  memory request valid.
- mem_ready_i  in  1  memory accepts request.
- mem_write_o  out  1  1 = write.
- mem_addr_o  out  32  word address, bits [1:0] = 0.
- mem_wstrb_o  out  4  byte enables; 0 for reads.
- mem_wdata_o  out  32  lane-replicated store data.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  32  read word.

## Operation
- Request fields are registered at acceptance (req_valid_i && req_ready_o). Inputs are ignored in all other states.
- FSM states: IDLE, REQ, WAIT_RDATA, RESP.
  - IDLE -> REQ on acceptance of a legal request.
  - IDLE -> RESP on acceptance of an error request; no memory access.
  - REQ: mem_valid_o = 1, all mem_* outputs stable until mem_ready_i.
    - Store handshake -> RESP.
    - Load handshake -> WAIT_RDATA.
  - WAIT_RDATA: on mem_rvalid_i, capture and extend the data, then -> RESP.
  - RESP: resp_valid_o = 1 for exactly one cycle, then -> IDLE.
- Store data path:
  - SB: wdata = {4{byte}}, wstrb = 4'b0001 << addr[1:0].
  - SH: wdata = {2{half}}, wstrb = addr[1] ? 4'b1100 : 4'b0011.
  - SW: wstrb = 4'b1111.
- Load data path: lane = rdata >> (8*addr[1:0]).
  - LB/LH: sign-extend. LBU/LHU: zero-extend. LW: pass the word through.
- Legal funct3 values:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Any other value sets resp_error_o = 1 with resp_rdata_o = 0.
- mem_rvalid_i outside WAIT_RDATA is ignored. mem_rvalid_i in the same cycle as the REQ handshake is ignored.

## Timing
- Reset values:
  - State IDLE; req_ready_o = 1.
  - All other outputs 0, including mem_valid_o, resp_valid_o, resp_rdata_o, resp_error_o, mem_addr_o, mem_wstrb_o, mem_wdata_o and mem_write_o.
- Acceptance in cycle T: mem_valid_o is high from T+1.
- Store with mem_ready_i at T+1: resp_valid_o at T+2.
- Load with mem_ready_i at T+1 and mem_rvalid_i at T+2: resp_valid_o at T+3. This is the minimum load latency.
- Error request: resp_valid_o at T+1.
- Every wait state on mem_ready_i or mem_rvalid_i adds exactly one cycle.
- Throughput: at most one request in flight. The next request can be accepted the cycle after RESP.
- Reset mid-operation aborts the access immediately. A late mem_ready_i or mem_rvalid_i after reset is ignored.

## Configuration
- TINY5_LSU_MISALIGN_TRAP_EN defined:
  - Misaligned accesses are halfword with addr[0] = 1, or word with addr[1:0] != 0.
  - They behave as error requests: resp_error_o = 1 at T+1, no memory transaction.
- Undefined:
  - Offending low address bits are ignored. Halfword uses addr[1] only; word is aligned down.
  - resp_error_o is raised only for illegal funct3.

## Test plan
- SB addr 0x1003, wdata 0x000000A5, mem_ready_i immediately -> at T+1: mem_addr_o 0x1000, wstrb 4'b1000, wdata 0xA5A5A5A5; resp_valid_o at T+2, resp_error_o 0.
- LB addr 0x2002, mem_rdata_i 0x1280FF34 -> resp_rdata_o 0xFFFFFF80. The same request as LBU -> 0x00000080. resp_valid_o at T+3.
- LH addr 0x2002, rdata 0x8001_7FFF, mem_ready_i held low 3 cycles and rvalid delayed 2 cycles -> mem_* outputs stable while waiting; resp 0xFFFF8001 at T+8.
- Load funct3 3'b011 -> resp_valid_o at T+1 with resp_error_o 1 and rdata 0; mem_valid_o never asserted.
- LW addr 0x3002: with the macro -> error at T+1, no memory access; without it -> mem_addr_o 0x3000 and normal response.
- reset_i asserted during WAIT_RDATA, then mem_rvalid_i pulsed -> no resp_valid_o, all outputs at reset values, req_ready_o 1.
